// File: rtl/pov_pkg.sv
// Shared types, default constants and width helpers for the POV column scheduler.
package pov_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEND,
        LATCH
    } sched_state_t;

    localparam int THETA_BITS   = 6;
    localparam int TEX_WIDTH    = 256;
    localparam int LED_COUNT    = 52;
    localparam int PX_BITS      = 6;
    localparam int LATCH_CYCLES = 8000;

    function automatic int col_width(input int tex_width);
        return $clog2(tex_width);
    endfunction

    function automatic int addr_width(input int tex_width, input int led_count);
        return $clog2(tex_width * led_count);
    endfunction

    function automatic int timer_width(input int latch_cycles);
        return (latch_cycles > 1) ? $clog2(latch_cycles) : 1;
    endfunction

endpackage

// File: rtl/pov_column_scheduler_if.sv
// Angle/strip/ROM-address bundle between the scheduler and its neighbours.
// drop_cnt exists only when POV_SCHED_STATS_EN is defined.
interface pov_column_scheduler_if #(
    parameter int THETA_BITS = pov_pkg::THETA_BITS,
    parameter int TEX_WIDTH  = pov_pkg::TEX_WIDTH,
    parameter int LED_COUNT  = pov_pkg::LED_COUNT,
    parameter int PX_BITS    = pov_pkg::PX_BITS
);
    localparam int COL_W  = pov_pkg::col_width(TEX_WIDTH);
    localparam int ADDR_W = pov_pkg::addr_width(TEX_WIDTH, LED_COUNT);

    logic                  en;
    logic [THETA_BITS-1:0] theta;
    logic                  strip_done;
    logic [PX_BITS-1:0]    next_px_num;
    logic                  strip_start;
    logic [COL_W-1:0]      col;
    logic [ADDR_W-1:0]     rom_addr;
    logic                  busy;
`ifdef POV_SCHED_STATS_EN
    logic [15:0]           drop_cnt;

    modport master (
        output en, theta, strip_done, next_px_num,
        input  strip_start, col, rom_addr, busy, drop_cnt
    );

    modport slave (
        input  en, theta, strip_done, next_px_num,
        output strip_start, col, rom_addr, busy, drop_cnt
    );
`else
    modport master (
        output en, theta, strip_done, next_px_num,
        input  strip_start, col, rom_addr, busy
    );

    modport slave (
        input  en, theta, strip_done, next_px_num,
        output strip_start, col, rom_addr, busy
    );
`endif
endinterface

// File: rtl/pov_latch_timer.sv
// Loadable down-counter with a zero flag; times the WS2812 latch gap.
module pov_latch_timer #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pov_column_scheduler.sv
// Fires one strip frame per new angle column and enforces the latch gap between frames.
// Define POV_SCHED_STATS_EN to add the saturating drop_cnt statistics counter.
module pov_column_scheduler #(
    parameter int THETA_BITS   = pov_pkg::THETA_BITS,
    parameter int TEX_WIDTH    = pov_pkg::TEX_WIDTH,
    parameter int LED_COUNT    = pov_pkg::LED_COUNT,
    parameter int PX_BITS      = pov_pkg::PX_BITS,
    parameter int LATCH_CYCLES = pov_pkg::LATCH_CYCLES
) (
    input logic                   clk,
    input logic                   rst_n,
    pov_column_scheduler_if.slave bus
);
    import pov_pkg::*;

    localparam int COL_W   = col_width(TEX_WIDTH);
    localparam int ADDR_W  = addr_width(TEX_WIDTH, LED_COUNT);
    localparam int CNT_W   = timer_width(LATCH_CYCLES);
    localparam int SHIFT   = COL_W - THETA_BITS;
    localparam int LAST_PX = LED_COUNT - 1;

    sched_state_t          state;
    sched_state_t          state_n;
    logic [THETA_BITS-1:0] theta_q;
    logic                  pending;
    logic                  change;
    logic                  strip_start;
    logic                  timer_load;
    logic                  timer_dec;
    logic                  timer_zero;
    logic                  busy_q;
    logic [COL_W-1:0]      col_q;
    logic [ADDR_W-1:0]     rom_addr_q;
    logic [PX_BITS-1:0]    px_clamped;

    assign change = (bus.theta != theta_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pending && bus.en) state_n = ARM;
            ARM:     state_n = SEND;
            SEND:    if (bus.strip_done) state_n = LATCH;
            LATCH:   if (timer_zero) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        strip_start = (state == ARM);
        timer_load  = (state == SEND) && bus.strip_done;
        timer_dec   = (state == LATCH);
    end

    pov_latch_timer #(
        .WIDTH(CNT_W)
    ) u_latch_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (CNT_W'(LATCH_CYCLES - 1)),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        px_clamped = bus.next_px_num;
        if (int'(bus.next_px_num) > LAST_PX) px_clamped = PX_BITS'(LAST_PX);
    end

    // A change landing in the ARM cycle keeps pending set so the newer angle gets its own frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            theta_q    <= '0;
            pending    <= 1'b0;
            col_q      <= '0;
            busy_q     <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            theta_q <= bus.theta;
            if (change) begin
                pending <= 1'b1;
            end else if (state == ARM) begin
                pending <= 1'b0;
            end
            if (state == ARM) begin
                col_q <= COL_W'(theta_q) << SHIFT;
            end
            busy_q     <= (state_n != IDLE);
            // TEX_WIDTH is a power of two, so row*TEX_WIDTH + col is a concatenation.
            rom_addr_q <= (ADDR_W'(px_clamped) << COL_W) | ADDR_W'(col_q);
        end
    end

`ifdef POV_SCHED_STATS_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (change && pending && state != ARM && drop_q != '1) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`endif

    assign bus.strip_start = strip_start;
    assign bus.col         = col_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_pov_column_scheduler.sv
// Self-checking bench for pov_column_scheduler against a rule-level reference model.
module tb_pov_column_scheduler;

    localparam int LAT = 8000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   starts = 0;
    int   exp_drop = 0;

    always #5 clk = ~clk;

    pov_column_scheduler_if bus_if ();

    pov_column_scheduler #(
        .THETA_BITS   (6),
        .TEX_WIDTH    (256),
        .LED_COUNT    (52),
        .PX_BITS      (6),
        .LATCH_CYCLES (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always @(negedge clk) begin
        if (rst_n && bus_if.strip_start === 1'b1) starts++;
    end

    // Each angle step spans TEX_WIDTH/2^THETA_BITS texture columns.
    function automatic int ref_col(input int th);
        return (th % 64) * (256 / 64);
    endfunction

    function automatic int ref_addr(input int px, input int c);
        int row;
        row = (px < 52) ? px : 51;
        return row * 256 + c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int px;
        int s0;
        rst_n = 1'b0;
        bus_if.en = 1'b0;
        bus_if.theta = '0;
        bus_if.strip_done = 1'b0;
        bus_if.next_px_num = 6'($urandom_range(0, 63));
        repeat (3) tick();
        checks++; if (bus_if.strip_start !== 1'b0) begin errors++; $display("FAIL reset_strip_start: got %0b want 0", bus_if.strip_start); end
        checks++; if (bus_if.col !== 8'd0) begin errors++; $display("FAIL reset_col: got %0d want 0", bus_if.col); end
        checks++; if (bus_if.rom_addr !== 14'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", bus_if.rom_addr); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus_if.busy); end
`ifdef POV_SCHED_STATS_EN
        checks++; if (bus_if.drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", bus_if.drop_cnt); end
`endif
        rst_n = 1'b1;
        bus_if.en = 1'b1;
        s0 = starts;
        for (int i = 0; i < 20; i++) begin
            px = int'($urandom_range(0, 63));
            bus_if.next_px_num = 6'(px);
            tick();
            checks++;
            if (bus_if.rom_addr !== 14'(ref_addr(px, 0))) begin
                errors++; $display("FAIL idle_rom_addr: px=%0d got %0d want %0d", px, bus_if.rom_addr, ref_addr(px, 0));
            end
        end
        checks++; if (starts != s0) begin errors++; $display("FAIL idle_no_start: got %0d starts want 0", starts - s0); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", bus_if.busy); end
    endtask

    task automatic test_single_column;
        int len;
        int px;
        int s0;
        tick();
        bus_if.theta = 6'd5;
        tick();
        checks++; if (bus_if.strip_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %0b want 0", bus_if.strip_start); end
        tick();
        checks++; if (bus_if.strip_start !== 1'b1) begin errors++; $display("FAIL single_start: got %0b want 1", bus_if.strip_start); end
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL single_busy_arm: got %0b want 1", bus_if.busy); end
        tick();
        checks++; if (bus_if.strip_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %0b want 0", bus_if.strip_start); end
        checks++; if (bus_if.col !== 8'(ref_col(5))) begin errors++; $display("FAIL single_col: got %0d want %0d", bus_if.col, ref_col(5)); end
        len = int'($urandom_range(3, 20));
        for (int i = 0; i < len; i++) begin
            px = int'($urandom_range(0, 63));
            bus_if.next_px_num = 6'(px);
            tick();
            checks++;
            if (bus_if.rom_addr !== 14'(ref_addr(px, ref_col(5)))) begin
                errors++; $display("FAIL send_rom_addr: px=%0d got %0d want %0d", px, bus_if.rom_addr, ref_addr(px, ref_col(5)));
            end
        end
        bus_if.strip_done = 1'b1;
        tick();
        bus_if.strip_done = 1'b0;
        s0 = starts;
        for (int i = 0; i < LAT - 1; i++) begin
            bus_if.strip_done = (i == 100);
            tick();
        end
        bus_if.strip_done = 1'b0;
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL latch_busy_end: got %0b want 1", bus_if.busy); end
        tick();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL latch_idle: got %0b want 0", bus_if.busy); end
        checks++; if (starts != s0) begin errors++; $display("FAIL latch_no_start: got %0d starts want 0", starts - s0); end
    endtask

    task automatic test_overwrite;
        int b;
        int s0;
        int len;
        bus_if.strip_done = 1'b1;
        tick();
        bus_if.strip_done = 1'b0;
        tick();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL done_in_idle: busy got %0b want 0", bus_if.busy); end
        b = int'($urandom_range(6, 58));
        bus_if.theta = 6'(b);
        tick();
        tick();
        checks++; if (bus_if.strip_start !== 1'b1) begin errors++; $display("FAIL ovw_first_start: got %0b want 1", bus_if.strip_start); end
        tick();
        checks++; if (bus_if.col !== 8'(ref_col(b))) begin errors++; $display("FAIL ovw_first_col: got %0d want %0d", bus_if.col, ref_col(b)); end
        tick();
        tick();
        bus_if.theta = 6'(b + 1);
        repeat (3) tick();
        bus_if.theta = 6'(b + 2);
        exp_drop++;
        repeat (2) tick();
        checks++; if (bus_if.col !== 8'(ref_col(b))) begin errors++; $display("FAIL ovw_col_hold: got %0d want %0d", bus_if.col, ref_col(b)); end
        bus_if.strip_done = 1'b1;
        tick();
        bus_if.strip_done = 1'b0;
        s0 = starts;
        repeat (LAT) tick();
        checks++; if (bus_if.strip_start !== 1'b0) begin errors++; $display("FAIL gap_early_start: got %0b want 0", bus_if.strip_start); end
        checks++; if (starts != s0) begin errors++; $display("FAIL gap_no_start: got %0d starts want 0", starts - s0); end
        tick();
        checks++; if (bus_if.strip_start !== 1'b1) begin errors++; $display("FAIL gap_start: got %0b want 1", bus_if.strip_start); end
        tick();
        checks++; if (bus_if.col !== 8'(ref_col(b + 2))) begin errors++; $display("FAIL ovw_newest_col: got %0d want %0d", bus_if.col, ref_col(b + 2)); end
        checks++; if (starts != s0 + 1) begin errors++; $display("FAIL ovw_one_frame: got %0d starts want 1", starts - s0); end
        len = int'($urandom_range(3, 20));
        repeat (len) tick();
        bus_if.strip_done = 1'b1;
        tick();
        bus_if.strip_done = 1'b0;
        repeat (LAT + 2) tick();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL ovw_idle: got %0b want 0", bus_if.busy); end
`ifdef POV_SCHED_STATS_EN
        checks++; if (bus_if.drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL ovw_drop_cnt: got %0d want %0d", bus_if.drop_cnt, exp_drop); end
`endif
    endtask

    task automatic test_enable_wrap_address;
        int s0;
        int px_list [6] = '{51, 60, 63, 0, 52, 50};
        bus_if.en = 1'b0;
        s0 = starts;
        bus_if.theta = 6'd62;
        repeat (2) tick();
        bus_if.theta = 6'd63;
        exp_drop++;
        repeat (10) tick();
        checks++; if (starts != s0) begin errors++; $display("FAIL en_low_no_start: got %0d starts want 0", starts - s0); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL en_low_busy: got %0b want 0", bus_if.busy); end
        bus_if.en = 1'b1;
        tick();
        checks++; if (bus_if.strip_start !== 1'b1) begin errors++; $display("FAIL en_rise_start: got %0b want 1", bus_if.strip_start); end
        tick();
        checks++; if (bus_if.col !== 8'(ref_col(63))) begin errors++; $display("FAIL en_col: got %0d want %0d", bus_if.col, ref_col(63)); end
        bus_if.en = 1'b0;
        foreach (px_list[k]) begin
            bus_if.next_px_num = 6'(px_list[k]);
            tick();
            checks++;
            if (bus_if.rom_addr !== 14'(ref_addr(px_list[k], ref_col(63)))) begin
                errors++; $display("FAIL addr_corner: px=%0d got %0d want %0d", px_list[k], bus_if.rom_addr, ref_addr(px_list[k], ref_col(63)));
            end
        end
        bus_if.strip_done = 1'b1;
        tick();
        bus_if.strip_done = 1'b0;
        s0 = starts;
        repeat (50) tick();
        bus_if.theta = 6'd0;
        repeat (LAT + 20) tick();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL en_low_frame_end: busy got %0b want 0", bus_if.busy); end
        checks++; if (starts != s0) begin errors++; $display("FAIL en_low_pending: got %0d starts want 0", starts - s0); end
        bus_if.en = 1'b1;
        tick();
        checks++; if (bus_if.strip_start !== 1'b1) begin errors++; $display("FAIL wrap_start: got %0b want 1", bus_if.strip_start); end
        tick();
        checks++; if (bus_if.col !== 8'(ref_col(0))) begin errors++; $display("FAIL wrap_col: got %0d want %0d", bus_if.col, ref_col(0)); end
`ifdef POV_SCHED_STATS_EN
        checks++; if (bus_if.drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL en_drop_cnt: got %0d want %0d", bus_if.drop_cnt, exp_drop); end
`endif
    endtask

    task automatic test_async_reset;
        int r;
        int s0;
        repeat (3) tick();
        #3;
        rst_n = 1'b0;
        #1;
        exp_drop = 0;
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %0b want 0", bus_if.busy); end
        checks++; if (bus_if.strip_start !== 1'b0) begin errors++; $display("FAIL areset_start: got %0b want 0", bus_if.strip_start); end
        checks++; if (bus_if.rom_addr !== 14'd0) begin errors++; $display("FAIL areset_rom_addr: got %0d want 0", bus_if.rom_addr); end
`ifdef POV_SCHED_STATS_EN
        checks++; if (bus_if.drop_cnt !== 16'd0) begin errors++; $display("FAIL areset_drop_cnt: got %0d want 0", bus_if.drop_cnt); end
`endif
        r = int'($urandom_range(1, 63));
        bus_if.theta = 6'(r);
        bus_if.en = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (bus_if.strip_start !== 1'b1) begin errors++; $display("FAIL post_reset_start: got %0b want 1", bus_if.strip_start); end
        tick();
        checks++; if (bus_if.col !== 8'(ref_col(r))) begin errors++; $display("FAIL post_reset_col: got %0d want %0d", bus_if.col, ref_col(r)); end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_if.col !== 8'd0) begin errors++; $display("FAIL areset2_col: got %0d want 0", bus_if.col); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL areset2_busy: got %0b want 0", bus_if.busy); end
        checks++; if (bus_if.rom_addr !== 14'd0) begin errors++; $display("FAIL areset2_rom_addr: got %0d want 0", bus_if.rom_addr); end
        bus_if.theta = '0;
        #2;
        rst_n = 1'b1;
        s0 = starts;
        repeat (10) tick();
        checks++; if (starts != s0) begin errors++; $display("FAIL areset2_no_start: got %0d starts want 0", starts - s0); end
    endtask

    initial begin
        test_reset();
        test_single_column();
        test_overwrite();
        test_enable_wrap_address();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pov_column_scheduler.md
# pov_column_scheduler

Sequences column refreshes for the POV display. Watches the angle index from the break-beam angle generator, latches the matching texture column, and fires one strip frame per new column. It keeps the column stable for the whole frame and enforces the WS2812 latch gap before the next frame. It sits between the theta generator, the texture ROM address path and the neopixel controller, replacing the free-running `start = 1` strobe.

## Interface
Parameters:
- `THETA_BITS`, 6: width of the angle index.
- `TEX_WIDTH`, 256: texture columns; a power of two, with `log2(TEX_WIDTH) >= THETA_BITS`.
- `LED_COUNT`, 52: LEDs per strip (texture rows).
- `PX_BITS`, 6: width of the pixel index from the strip controller.
- `LATCH_CYCLES`, 8000: idle clocks after a frame (80 µs at 100 MHz); minimum 1.

Ports:
- `clk`, in, 1: 100 MHz board clock.
- `rst_n`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `en`, in, 1: when low, no new frame starts; a frame already in flight completes.
- `theta`, in, THETA_BITS: current angle index.
- `strip_done`, in, 1: one-cycle pulse from the strip controller after the last pixel is shifted.
- `next_px_num`, in, PX_BITS: pixel index requested by the strip controller.
- `strip_start`, out, 1: one-cycle frame-start pulse.
- `col`, out, log2(TEX_WIDTH): latched column for the current frame.
- `rom_addr`, out, log2(TEX_WIDTH*LED_COUNT): registered texture ROM address.
- `busy`, out, 1: high in ARM, SEND and LATCH.
- `drop_cnt`, out, 16: saturating count of overwritten column requests (present only with the stats macro).

## Operation
- `theta_q` is a registered copy of `theta`. A change is detected when `theta != theta_q` and sets `pending`. The newest theta always wins.
- FSM states:
  - IDLE: if `pending && en`, go to ARM.
  - ARM, 1 cycle:
    - `col <= theta_q << (log2(TEX_WIDTH)-THETA_BITS)`.
    - Clear `pending`.
    - Assert `strip_start`.
    - Go to SEND.
  - SEND: hold `col`. On `strip_done`, load the latch counter with `LATCH_CYCLES-1` and go to LATCH.
  - LATCH: decrement the counter; at 0, go to IDLE.
- `rom_addr <= next_px_num * TEX_WIDTH + col`, registered every cycle. The width is computed in full, with no truncation for legal `next_px_num < LED_COUNT`. A `next_px_num >= LED_COUNT` is clamped to `LED_COUNT-1`.
- Boundary rules:
  - Change detected in the same cycle ARM clears `pending`: set wins, `pending` stays 1.
  - Change detected while `pending` is already 1: the request is overwritten and `drop_cnt` increments, saturating at 0xFFFF.
  - `strip_done` outside SEND is ignored.
  - Theta wrap from 63 to 0 is an ordinary change.
  - `en` falling during ARM, SEND or LATCH has no effect until IDLE is reached.
- Reset, asynchronous, legal mid-frame: state IDLE, `pending=0`, `theta_q=0`, `col=0`, `rom_addr=0`, `strip_start=0`, `busy=0`, `drop_cnt=0`.

## Timing
- A theta change at edge N is detected at N+1. The FSM enters ARM at N+2, where `strip_start` is high and `col` becomes valid after the edge. SEND begins at N+3.
- `rom_addr` lags `next_px_num` by exactly 1 cycle. The ROM adds its own 1 cycle on top.
- Minimum spacing between `strip_start` pulses: the frame length, plus `LATCH_CYCLES`, plus 2.
- `busy` is registered and equals `state != IDLE`.

## Configuration
- `POV_SCHED_STATS_EN`:
  - Defined: the `drop_cnt` port and its counter exist.
  - Undefined: the port and counter are omitted. All other behaviour is identical, including the overwrite itself.

## Structure
- Shared package `pov_pkg`:
  - FSM state enum: IDLE, ARM, SEND, LATCH.
  - Default constants: `LED_COUNT`, `TEX_WIDTH`, `THETA_BITS`, `LATCH_CYCLES`.
  - Column and address width functions.
- One natural sub-module, `pov_latch_timer`: a loadable down-counter with a zero flag, used for LATCH.

## Test plan
- Reset and idle: with `rst_n` low and theta held at 0, every output is 0. After release with no theta change, `strip_start` never pulses.
- Single column: theta changes 0 to 5 at cycle 10. Then `strip_start` pulses at cycle 12 only, `col=20`, and `busy` is high from cycle 12.
- Overwrite: during SEND, theta steps 5 to 6 to 7. After `strip_done` plus 8000 cycles, exactly one frame starts with `col=28`, and `drop_cnt=1`.
- Latch gap: `strip_done` at cycle T gives a next `strip_start` no earlier than T+8001, with a pending change present.
- Address math: `col=255` with `next_px_num=51` gives `rom_addr=13311` one cycle later; `next_px_num=60` clamps to 13311.
- Asynchronous reset and enable: `rst_n` pulsed low mid-SEND immediately drives IDLE and zero outputs. With `en=0` and changes pending, there is no `strip_start`; raising `en` produces a start 1 cycle later.
